multi_channel_dds: RTL and testbench

//  N-channel direct digital synthesis waveform generator. It is the parametrised successor of the two-channel generator.

---
 rtl/multi_channel_dds.sv | 175 +++++++++++++++++
 tb/tb_multi_channel_dds.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_dds.sv
// N-channel DDS waveform generator: per-channel phase accumulator, burst counter and
// IDLE/RUN/DONE control, producing DC/sine/saw/triangle/square samples two clocks after a tick.
module multi_channel_dds #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned CYC_W   = 16,
  parameter int unsigned LUT_AW  = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        sample_tick_i,
  input  logic [NUM_CH-1:0]           start_i,
  input  logic [NUM_CH-1:0]           stop_i,
  input  logic [NUM_CH*3-1:0]         mode_i,
  input  logic [NUM_CH*PHASE_W-1:0]   freq_word_i,
  input  logic [NUM_CH*PHASE_W-1:0]   phase_offs_i,
  input  logic [NUM_CH*16-1:0]        duty_i,
  input  logic [NUM_CH*OUT_W-1:0]     dc_level_i,
  input  logic [NUM_CH*CYC_W-1:0]     cycles_i,
  output logic [NUM_CH*LUT_AW-1:0]    lut_addr_o,
  input  logic [NUM_CH*OUT_W-1:0]     lut_data_i,
  output logic [NUM_CH*OUT_W-1:0]     wave_o,
  output logic [NUM_CH-1:0]           wave_valid_o,
  output logic [NUM_CH-1:0]           busy_o,
  output logic [NUM_CH-1:0]           done_o
);

  // Only the top OUT_W+1 phase bits feed any waveform, so only those are registered.
  localparam int unsigned PW = OUT_W + 1;
  localparam logic [OUT_W-1:0] MaxVal = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NegMax = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_e              state_q, state_d;
    logic [2:0]          mode_q, mode_d;
    logic [PHASE_W-1:0]  fw_q, fw_d, offs_q, offs_d, acc_q, acc_d;
    logic [15:0]         duty_q, duty_d;
    logic [OUT_W-1:0]    dc_q, dc_d, wave_q, wave_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d, cnt_q, cnt_d;
    logic [PW-1:0]       p_q, p_d;
    logic [LUT_AW-1:0]   addr_q, addr_d;
    logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic                vld_q, vld_d, done_q, done_d, busy_q, busy_d;
    logic [PHASE_W:0]    sum;
    logic [OUT_W-1:0]    u, tri_v, smp;
    logic [OUT_W-2:0]    f;
    logic                wrap, tick_run, last;

    always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      fw_d      = fw_q;
      offs_d    = offs_q;
      duty_d    = duty_q;
      dc_d      = dc_q;
      cyc_d     = cyc_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      addr_d    = addr_q;
      wave_d    = wave_q;
      s1_vld_d  = 1'b0;
      s1_last_d = 1'b0;
      vld_d     = 1'b0;
      done_d    = 1'b0;

      sum      = {1'b0, acc_q} + {1'b0, fw_q};
      wrap     = sum[PHASE_W];
      tick_run = sample_tick_i && (state_q == StRun) && !start_i[c] && !stop_i[c];
      last     = tick_run && wrap && (cyc_q != '0) && ((cnt_q + CYC_W'(1)) == cyc_q);

      u = p_q[PW-1 -: OUT_W];
      f = p_q[PW-3 -: OUT_W-1];
      case (p_q[PW-1 -: 2])
        2'd0:    tri_v = {1'b0, f};
        2'd1:    tri_v = MaxVal - {1'b0, f};
        2'd2:    tri_v = '0 - {1'b0, f};
        default: tri_v = {1'b0, f} - MaxVal;
      endcase
      case (mode_q)
        3'd1:    smp = lut_data_i[c*OUT_W +: OUT_W];
        3'd2:    smp = {~u[OUT_W-1], u[OUT_W-2:0]};
        3'd3:    smp = tri_v;
        3'd4:    smp = (p_q[PW-1 -: 16] < duty_q) ? MaxVal : NegMax;
        default: smp = dc_q;
      endcase

      // Stop wins over a simultaneous start.
      if (stop_i[c]) begin
        state_d = StIdle;
      end else if (start_i[c]) begin
        state_d = StRun;
        mode_d  = mode_i[c*3 +: 3];
        fw_d    = freq_word_i[c*PHASE_W +: PHASE_W];
        offs_d  = phase_offs_i[c*PHASE_W +: PHASE_W];
        duty_d  = duty_i[c*16 +: 16];
        dc_d    = dc_level_i[c*OUT_W +: OUT_W];
        cyc_d   = cycles_i[c*CYC_W +: CYC_W];
        acc_d   = '0;
        cnt_d   = '0;
      end else if (tick_run) begin
        p_d       = PW'((acc_q + offs_q) >> (PHASE_W - PW));
        addr_d    = p_d[PW-1 -: LUT_AW];
        acc_d     = sum[PHASE_W-1:0];
        s1_vld_d  = 1'b1;
        s1_last_d = last;
        if (wrap && (cyc_q != '0)) cnt_d = cnt_q + CYC_W'(1);
        if (last) state_d = StDone;
      end

      // The final burst sample still drains; anything in flight at a stop is dropped.
      if (stop_i[c]) begin
        wave_d = '0;
      end else if (s1_vld_q) begin
        wave_d = smp;
        vld_d  = 1'b1;
        done_d = s1_last_q;
      end else if (state_q != StRun) begin
        wave_d = '0;
      end

      busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q   <= StIdle;
        mode_q    <= '0;
        fw_q      <= '0;
        offs_q    <= '0;
        duty_q    <= '0;
        dc_q      <= '0;
        cyc_q     <= '0;
        acc_q     <= '0;
        cnt_q     <= '0;
        p_q       <= '0;
        addr_q    <= '0;
        wave_q    <= '0;
        s1_vld_q  <= 1'b0;
        s1_last_q <= 1'b0;
        vld_q     <= 1'b0;
        done_q    <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        mode_q    <= mode_d;
        fw_q      <= fw_d;
        offs_q    <= offs_d;
        duty_q    <= duty_d;
        dc_q      <= dc_d;
        cyc_q     <= cyc_d;
        acc_q     <= acc_d;
        cnt_q     <= cnt_d;
        p_q       <= p_d;
        addr_q    <= addr_d;
        wave_q    <= wave_d;
        s1_vld_q  <= s1_vld_d;
        s1_last_q <= s1_last_d;
        vld_q     <= vld_d;
        done_q    <= done_d;
        busy_q    <= busy_d;
      end
    end

    assign lut_addr_o[c*LUT_AW +: LUT_AW] = addr_q;
    assign wave_o[c*OUT_W +: OUT_W]       = wave_q;
    assign wave_valid_o[c]                = vld_q;
    assign busy_o[c]                      = busy_q;
    assign done_o[c]                      = done_q;
  end

endmodule

// File: tb/tb_multi_channel_dds.sv
// Self-checking bench for multi_channel_dds: fixed waveform tables plus randomized
// configurations compared against a phase-arithmetic reference model.
module tb_multi_channel_dds;
  localparam int NCH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         sample_tick;
  logic [3:0]   start, stop;
  logic [11:0]  mode;
  logic [127:0] freq_word, phase_offs;
  logic [63:0]  duty, dc_level, cycles;
  logic [39:0]  lut_addr;
  logic [63:0]  lut_data, wave;
  logic [3:0]   wave_valid, busy, done;

  int checks = 0;
  int errors = 0;

  logic [2:0]  m_mode [NCH];
  logic [31:0] m_fw   [NCH];
  logic [31:0] m_offs [NCH];
  logic [15:0] m_duty [NCH];
  logic [15:0] m_dc   [NCH];
  logic [15:0] m_cyc  [NCH];

  logic [15:0] exp_saw [4] = '{16'h8000, 16'hC000, 16'h0000, 16'h4000};
  logic [15:0] exp_tri [8] = '{16'h0000, 16'h4000, 16'h7FFF, 16'h3FFF,
                               16'h0000, 16'hC000, 16'h8001, 16'hC001};
  logic [15:0] exp_sq0 [4] = '{16'h7FFF, 16'h8001, 16'h8001, 16'h8001};
  logic [15:0] exp_sq1 [4] = '{16'h8001, 16'h8001, 16'h7FFF, 16'h8001};

  always #5 clk = ~clk;

  // Stub sine LUT: data equals address.
  for (genvar g = 0; g < NCH; g++) begin : g_lut
    assign lut_data[g*16 +: 16] = {6'b0, lut_addr[g*10 +: 10]};
  end

  multi_channel_dds #(
    .NUM_CH (4),
    .PHASE_W(32),
    .OUT_W  (16),
    .CYC_W  (16),
    .LUT_AW (10)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .sample_tick_i(sample_tick),
    .start_i      (start),
    .stop_i       (stop),
    .mode_i       (mode),
    .freq_word_i  (freq_word),
    .phase_offs_i (phase_offs),
    .duty_i       (duty),
    .dc_level_i   (dc_level),
    .cycles_i     (cycles),
    .lut_addr_o   (lut_addr),
    .lut_data_i   (lut_data),
    .wave_o       (wave),
    .wave_valid_o (wave_valid),
    .busy_o       (busy),
    .done_o       (done)
  );

  // Sample k of a channel: phase = offs + k*fw, shaped by the mode's definition.
  function automatic logic [15:0] ref_wave(int ch, int k);
    logic [31:0] p;
    int v;
    int r;
    p = m_offs[ch] + m_fw[ch] * 32'(k);
    v = int'(p >> 15);
    case (m_mode[ch])
      3'd1: r = int'(p >> 22);
      3'd2: r = int'(p >> 16) - 32768;
      3'd3: begin
        if (v < 32768)      r = v;
        else if (v < 65536) r = 65535 - v;
        else if (v < 98304) r = 65536 - v;
        else                r = v - 131071;
      end
      3'd4: r = (int'(p >> 16) < int'(m_duty[ch])) ? 32767 : -32767;
      default: r = int'($signed(m_dc[ch]));
    endcase
    return r[15:0];
  endfunction

  // Samples in a burst: smallest n with floor(n*fw / 2**32) == cycles.
  function automatic int burst_len(int ch);
    logic [63:0] num;
    num = 64'(m_cyc[ch]) << 32;
    return int'((num + 64'(m_fw[ch]) - 64'd1) / 64'(m_fw[ch]));
  endfunction

  task automatic cfg(input int ch, input logic [2:0] m, input logic [31:0] fw,
                     input logic [31:0] offs, input logic [15:0] d, input logic [15:0] dc,
                     input logic [15:0] cyc);
    mode[ch*3 +: 3]        = m;
    freq_word[ch*32 +: 32] = fw;
    phase_offs[ch*32 +: 32] = offs;
    duty[ch*16 +: 16]      = d;
    dc_level[ch*16 +: 16]  = dc;
    cycles[ch*16 +: 16]    = cyc;
    m_mode[ch] = m;
    m_fw[ch]   = fw;
    m_offs[ch] = offs;
    m_duty[ch] = d;
    m_dc[ch]   = dc;
    m_cyc[ch]  = cyc;
  endtask

  task automatic scramble();
    mode       = 12'($urandom);
    freq_word  = {$urandom, $urandom, $urandom, $urandom};
    phase_offs = {$urandom, $urandom, $urandom, $urandom};
    duty       = {$urandom, $urandom};
    dc_level   = {$urandom, $urandom};
    cycles     = {$urandom, $urandom};
  endtask

  task automatic pulse(input logic [3:0] st, input logic [3:0] sp);
    start = st;
    stop  = sp;
    @(negedge clk);
    start = '0;
    stop  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++; if (wave !== '0) begin errors++; $display("FAIL reset_wave: got %h expected 0", wave); end
    checks++; if (wave_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wave_valid); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (lut_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", lut_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== '0 || wave_valid !== '0) begin
      errors++; $display("FAIL idle_after_reset: busy %b valid %b expected 0", busy, wave_valid);
    end
  endtask

  task automatic test_saw();
    pulse(4'h0, 4'hF);
    cfg(0, 3'd2, 32'h4000_0000, 32'h0, 16'h0, 16'h0, 16'h0);
    pulse(4'b0001, 4'b0000);
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL saw_busy: got %b expected 1", busy[0]); end
    @(negedge clk);
    checks++; if (wave_valid[0] !== 1'b0) begin errors++; $display("FAIL saw_early_valid: got %b expected 0", wave_valid[0]); end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (wave_valid[0] !== 1'b1 || wave[15:0] !== exp_saw[k % 4]) begin
        errors++;
        $display("FAIL saw k%0d: got %h valid %b expected %h", k, wave[15:0], wave_valid[0], exp_saw[k % 4]);
      end
    end
  endtask

  task automatic test_tri();
    pulse(4'h0, 4'hF);
    cfg(1, 3'd3, 32'h2000_0000, 32'h0, 16'h0, 16'h0, 16'h0);
    pulse(4'b0010, 4'b0000);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (wave_valid[1] !== 1'b1 || wave[31:16] !== exp_tri[k % 8]) begin
        errors++;
        $display("FAIL tri k%0d: got %h valid %b expected %h", k, wave[31:16], wave_valid[1], exp_tri[k % 8]);
      end
    end
  endtask

  task automatic test_square();
    pulse(4'h0, 4'hF);
    cfg(2, 3'd4, 32'h4000_0000, 32'h0, 16'h4000, 16'h0, 16'h0);
    pulse(4'b0100, 4'b0000);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (wave[47:32] !== exp_sq0[k % 4]) begin
        errors++; $display("FAIL square k%0d: got %h expected %h", k, wave[47:32], exp_sq0[k % 4]);
      end
    end
    // Restart while running relatches the new offset.
    cfg(2, 3'd4, 32'h4000_0000, 32'h8000_0000, 16'h4000, 16'h0, 16'h0);
    pulse(4'b0100, 4'b0000);
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (wave[47:32] !== exp_sq1[k % 4]) begin
        errors++; $display("FAIL square_offs k%0d: got %h expected %h", k, wave[47:32], exp_sq1[k % 4]);
      end
    end
  endtask

  task automatic test_burst();
    int nv, nd, done_at, last_v;
    pulse(4'h0, 4'hF);
    cfg(3, 3'd2, 32'h4000_0000, 32'h0, 16'h0, 16'h0, 16'd3);
    for (int rep = 0; rep < 2; rep++) begin
      nv = 0; nd = 0; done_at = -1; last_v = -2;
      pulse(4'b1000, 4'b0000);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (wave_valid[3]) begin
          checks++;
          if (wave[63:48] !== ref_wave(3, nv)) begin
            errors++; $display("FAIL burst_sample r%0d k%0d: got %h expected %h", rep, nv, wave[63:48], ref_wave(3, nv));
          end
          nv++;
          last_v = i;
        end
        if (done[3]) begin nd++; done_at = i; end
      end
      checks++; if (nv !== burst_len(3)) begin errors++; $display("FAIL burst_count r%0d: got %0d expected %0d", rep, nv, burst_len(3)); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL burst_done r%0d: got %0d expected 1", rep, nd); end
      checks++; if (done_at !== last_v) begin errors++; $display("FAIL burst_done_pos r%0d: got %0d expected %0d", rep, done_at, last_v); end
      checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL burst_busy r%0d: got %b expected 0", rep, busy[3]); end
      checks++; if (wave[63:48] !== 16'h0) begin errors++; $display("FAIL burst_wave0 r%0d: got %h expected 0", rep, wave[63:48]); end
    end
  endtask

  task automatic test_stop();
    bit bad;
    pulse(4'h0, 4'hF);
    cfg(0, 3'd2, $urandom, $urandom, 16'h0, 16'h0, 16'h0);
    cfg(1, 3'd3, $urandom, $urandom, 16'h0, 16'h0, 16'h0);
    pulse(4'b0011, 4'b0000);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int ch = 0; ch < 2; ch++) begin
        checks++;
        if (wave_valid[ch] !== 1'b1 || wave[ch*16 +: 16] !== ref_wave(ch, k)) begin
          errors++; $display("FAIL stop_pre ch%0d k%0d: got %h expected %h", ch, k, wave[ch*16 +: 16], ref_wave(ch, k));
        end
      end
    end
    start[0] = 1'b1;
    stop[0]  = 1'b1;
    @(negedge clk);
    start = '0;
    stop  = '0;
    for (int k = 5; k < 14; k++) begin
      if (k > 5) @(negedge clk);
      bad = (wave[15:0] !== 16'h0) || (wave_valid[0] !== 1'b0) || (busy[0] !== 1'b0) || (done[0] !== 1'b0);
      checks++;
      if (bad) begin
        errors++; $display("FAIL stop_ch0 k%0d: got wave %h valid %b busy %b done %b expected all 0",
                           k, wave[15:0], wave_valid[0], busy[0], done[0]);
      end
      checks++;
      if (wave_valid[1] !== 1'b1 || wave[31:16] !== ref_wave(1, k)) begin
        errors++; $display("FAIL stop_ch1 k%0d: got %h expected %h", k, wave[31:16], ref_wave(1, k));
      end
    end
  endtask

  task automatic test_sine();
    logic [9:0] prev;
    pulse(4'h0, 4'hF);
    cfg(0, 3'd1, $urandom, $urandom, 16'h0, 16'h0, 16'h0);
    pulse(4'b0001, 4'b0000);
    @(negedge clk);
    prev = lut_addr[9:0];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (wave[15:0] !== {6'b0, prev} || wave[15:0] !== ref_wave(0, k)) begin
        errors++; $display("FAIL sine k%0d: got %h expected addr %h model %h", k, wave[15:0], prev, ref_wave(0, k));
      end
      prev = lut_addr[9:0];
    end
  endtask

  task automatic test_random();
    int nv [NCH];
    int nd [NCH];
    int expn;
    for (int r = 0; r < 4; r++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (r < 2)
          cfg(ch, 3'($urandom_range(7, 0)), $urandom, $urandom, 16'($urandom), 16'($urandom), 16'h0);
        else
          cfg(ch, 3'($urandom_range(7, 0)), $urandom_range(32'hFFFF_FFFF, 32'h2000_0000), $urandom,
              16'($urandom), 16'($urandom), 16'($urandom_range(2, 1)));
        nv[ch] = 0;
        nd[ch] = 0;
      end
      pulse(4'hF, 4'h0);
      scramble();
      @(negedge clk);
      checks++; if (wave_valid !== 4'h0) begin errors++; $display("FAIL rand_gap r%0d: got %b expected 0", r, wave_valid); end
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
          if (wave_valid[ch]) begin
            checks++;
            if (wave[ch*16 +: 16] !== ref_wave(ch, nv[ch])) begin
              errors++; $display("FAIL rand r%0d ch%0d k%0d mode %0d: got %h expected %h",
                                 r, ch, nv[ch], m_mode[ch], wave[ch*16 +: 16], ref_wave(ch, nv[ch]));
            end
            nv[ch]++;
          end
          if (done[ch]) nd[ch]++;
        end
      end
      for (int ch = 0; ch < NCH; ch++) begin
        expn = (m_cyc[ch] == 16'h0) ? 24 : burst_len(ch);
        checks++;
        if (nv[ch] !== expn || nd[ch] !== ((m_cyc[ch] == 16'h0) ? 0 : 1)) begin
          errors++; $display("FAIL rand_count r%0d ch%0d: got %0d samples %0d done expected %0d samples",
                             r, ch, nv[ch], nd[ch], expn);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nv, nd;
    pulse(4'h0, 4'hF);
    cfg(3, 3'd3, 32'h4000_0000, 32'h0, 16'h0, 16'h0, 16'd3);
    cfg(0, 3'd0, 32'h1000_0000, 32'h0, 16'h0, 16'h1234, 16'h0);
    pulse(4'b1001, 4'b0000);
    for (int i = 0; i < 6; i++) @(negedge clk);
    checks++; if (wave[15:0] !== 16'h1234) begin errors++; $display("FAIL midrst_pre: got %h expected 1234", wave[15:0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wave !== '0) begin errors++; $display("FAIL midrst_wave: got %h expected 0", wave); end
    checks++; if (wave_valid !== '0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", wave_valid); end
    checks++; if (busy !== '0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (lut_addr !== '0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", lut_addr); end
    @(negedge clk);
    rst = 1'b0;
    nv = 0; nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wave_valid != 4'h0) nv++;
      if (done != 4'h0) nd++;
    end
    checks++; if (nv !== 0 || nd !== 0 || busy !== 4'h0) begin
      errors++; $display("FAIL midrst_after: got %0d valids %0d dones busy %b expected none", nv, nd, busy);
    end
  endtask

  initial begin
    rst = 1'b1; sample_tick = 1'b1; start = '0; stop = '0;
    mode = '0; freq_word = '0; phase_offs = '0; duty = '0; dc_level = '0; cycles = '0;
    test_reset();
    test_saw();
    test_tri();
    test_square();
    test_burst();
    test_stop();
    test_sine();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
